blob_frame_binarizer: RTL and testbench
=======================================

// Module: blob_frame_binarizer
// PURPOSE
//  Upstream feeder of the blob counter. Captures one camera frame on request and thresholds each
//  pixel's gray level to 1 bit into an on-chip frame bit-buffer. After capture, it replays the
//  frame as a gap-free, 1-bit-per-cycle raster stream with a start pulse. The blob counter needs
//  this because it has no backpressure. Then waits for the counter's result before re-arming.
// PARAMETERS
//  IMG_COL   640  pixels per row
//  IMG_ROW   480  rows per frame; N = IMG_COL*IMG_ROW bits buffered (addr width clog2(N))
//  PIX_W     10   width of each R/G/B component
//  TAIL      2    extra o_seq=0 cycles driven after the last frame bit
// PORTS
//  i_clk         in   1      clock
//  i_rst_n       in   1      async active-low reset
//  i_trigger     in   1      request one capture (level or pulse; sampled in S_IDLE only)
//  i_pix_valid   in   1      camera pixel qualifier
//  i_sof         in   1      first pixel of a frame; valid only with i_pix_valid=1
//  i_r,i_g,i_b   in   PIX_W  pixel components
//  i_thresh      in   PIX_W  binarize threshold, sampled at capture start
//  i_invert      in   1      1: bit = gray < thresh; sampled at capture start
//  i_blob_done   in   1      one-cycle result-valid from blob counter
//  o_valid       out  1      one-cycle start pulse to blob counter (its i_valid)
//  o_seq         out  1      pixel bit stream (its i_seq)
//  o_busy        out  1      high in every state except S_IDLE
//  o_ones        out  19     count of 1-bits in last captured frame (saturates at 2^19-1)
// BEHAVIOUR
//  Reset is asynchronous, active-low, on i_rst_n; clock is i_clk.
//  Reset: state S_IDLE; o_valid=0, o_seq=0, o_busy=0, o_ones=0; address/counters=0. Buffer contents are don't-care.
//  Reset asserted mid-operation aborts immediately. After release, only a new trigger starts work.
//  gray = (R + 2G + B) >> 2, computed at PIX_W+2 bits with no overflow, result truncated to PIX_W.
//  bit = (gray >= thresh_q) ^ invert_q.
//  FSM:
//   S_IDLE:    if i_trigger: latch i_thresh/i_invert, clear o_ones -> S_WAITSOF.
//   S_WAITSOF: ignore pixels until i_pix_valid & i_sof. That pixel is written at addr 0 -> S_CAPTURE.
//   S_CAPTURE: each i_pix_valid writes a bit at addr+1 and increments o_ones if bit=1.
//              i_sof with i_pix_valid restarts: write addr 0, clear o_ones, stay.
//              After writing addr N-1 -> S_START. Cycles without i_pix_valid write nothing.
//   S_START:   o_valid=1 for exactly one cycle, read addr 0 issued -> S_STREAM.
//   S_STREAM:  buffer bit k appears on o_seq in the (k+1)-th cycle after the o_valid cycle, for k=0..N-1.
//              No gaps. The 1-cycle RAM read latency is hidden by prefetch. Then TAIL cycles of o_seq=0 -> S_WAIT.
//   S_WAIT:    o_seq=0; on i_blob_done -> S_IDLE.
//  o_seq=0 in every state except S_STREAM bit cycles.
//  Camera input during S_START/S_STREAM/S_WAIT is ignored. i_trigger outside S_IDLE is ignored.
//  i_blob_done outside S_WAIT is ignored.
//  Capture pixels beyond N never occur, since the FSM leaves S_CAPTURE at N.
//  A frame with fewer than N pixels stays in S_CAPTURE until the next SOF restarts it.
//  Buffer: single N x 1 simple dual-port RAM (M9K inference), one write port, one read port, registered read.
// TESTING (sim with IMG_COL=8, IMG_ROW=4, N=32, TAIL=2)
//  1 All pixels R=G=B=600, thresh=512, invert=0 -> o_ones=32.
//    o_valid one pulse, then o_seq=1 for exactly 32 consecutive cycles, then 0. o_busy high until i_blob_done.
//  2 Checkerboard, gray 0/1023, thresh=512, i_pix_valid toggling every other cycle.
//    Streamed bits match the raster pattern exactly and with no gaps; o_ones=16.
//  3 Same frame with invert=1 -> stream is the bitwise complement; o_ones=16.
//    Changing i_thresh mid-capture has no effect.
//  4 Pixels before SOF are ignored. A second SOF at pixel 10 restarts capture.
//    The output reflects only the post-restart 32 pixels.
//  5 i_trigger pulsed during S_STREAM and S_WAIT -> no new capture.
//    i_blob_done during S_STREAM is ignored. Done in S_WAIT -> o_busy=0 next cycle.
//  6 i_rst_n low mid-S_STREAM -> o_seq, o_valid, o_busy and o_ones all 0 immediately.
//    Stays idle until the next i_trigger.

Source files
------------

// File: rtl/blob_frame_binarizer.sv
// Captures one camera frame as 1-bit thresholded pixels into an on-chip bit buffer,
// then replays it as a gap-free raster stream with a start pulse for the blob counter.

module blob_frame_bit_ram #(
   parameter int DEPTH = 307200,
   parameter int AW    = 19
) (
   input  logic          i_clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic          wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic          rd_data_o
);

   logic mem [DEPTH];
   logic rd_data_q;

   // NOTE: the array and its read register carry no reset, so the tools can map
   // them onto a block RAM; contents are meaningless until a frame is captured.
   always_ff @(posedge i_clk) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

module blob_frame_binarizer #(
   parameter int IMG_COL = 640,
   parameter int IMG_ROW = 480,
   parameter int PIX_W   = 10,
   parameter int TAIL    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_trigger,
   input  logic             i_pix_valid,
   input  logic             i_sof,
   input  logic [PIX_W-1:0] i_r,
   input  logic [PIX_W-1:0] i_g,
   input  logic [PIX_W-1:0] i_b,
   input  logic [PIX_W-1:0] i_thresh,
   input  logic             i_invert,
   input  logic             i_blob_done,
   output logic             o_valid,
   output logic             o_seq,
   output logic             o_busy,
   output logic [18:0]      o_ones
);

   localparam int N  = IMG_COL * IMG_ROW;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N + TAIL + 1);
   localparam int OW = 19;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITSOF,
      S_CAPTURE,
      S_START,
      S_STREAM,
      S_WAIT
   } state_t;

   state_t           state_q;
   logic [PIX_W-1:0] thresh_q;
   logic             invert_q;
   logic [AW-1:0]    addr_q;
   logic [OW-1:0]    ones_q;
   logic [CW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             valid_q;
   logic             seq_q;
   logic             busy_q;

   logic [PIX_W+1:0] gray_sum;
   logic [PIX_W+1:0] gray;
   logic             pix_bit;
   logic             sof_hit;
   logic             last_wr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic             rd_data;
   logic [OW-1:0]    ones_inc;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      gray_sum = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
      gray     = gray_sum >> 2;
      pix_bit  = (gray >= {2'b00, thresh_q}) ^ invert_q;
      sof_hit  = i_pix_valid & i_sof;
      ones_inc = (ones_q == '1) ? ones_q : ones_q + 1'b1;
      last_wr  = (state_q == S_CAPTURE) && i_pix_valid && !i_sof &&
                 (addr_q == AW'(N - 2));
      wr_en    = 1'b0;
      wr_addr  = '0;
      rd_en    = 1'b0;
      rd_addr  = '0;
      case (state_q)
         S_WAITSOF: begin
            wr_en = sof_hit;
         end
         S_CAPTURE: begin
            wr_en   = i_pix_valid;
            wr_addr = i_sof ? '0 : addr_q + 1'b1;
         end
         S_START, S_STREAM: begin
            rd_en   = (rd_ptr_q < CW'(N));
            rd_addr = rd_ptr_q[AW-1:0];
         end
         default: ;
      endcase
      // Bit 0 is prefetched while the final pixel is written, so it is ready in S_START.
      if (last_wr) begin
         rd_en   = 1'b1;
         rd_addr = '0;
      end
   end

   blob_frame_bit_ram #(
      .DEPTH (N),
      .AW    (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (pix_bit),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         thresh_q <= '0;
         invert_q <= 1'b0;
         addr_q   <= '0;
         ones_q   <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         seq_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_trigger) begin
                  thresh_q <= i_thresh;
                  invert_q <= i_invert;
                  ones_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_WAITSOF;
               end
            end
            S_WAITSOF: begin
               if (sof_hit) begin
                  addr_q  <= '0;
                  ones_q  <= {{(OW-1){1'b0}}, pix_bit};
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (i_pix_valid) begin
                  if (i_sof) begin
                     addr_q <= '0;
                     ones_q <= {{(OW-1){1'b0}}, pix_bit};
                  end else begin
                     addr_q <= addr_q + 1'b1;
                     if (pix_bit) ones_q <= ones_inc;
                     if (last_wr) begin
                        valid_q  <= 1'b1;
                        rd_ptr_q <= CW'(1);
                        cnt_q    <= '0;
                        state_q  <= S_START;
                     end
                  end
               end
            end
            S_START: begin
               valid_q  <= 1'b0;
               seq_q    <= rd_data;
               rd_ptr_q <= rd_ptr_q + 1'b1;
               state_q  <= S_STREAM;
            end
            S_STREAM: begin
               // Last data bit is on o_seq once cnt_q reaches N-1; the rest is tail.
               seq_q <= (cnt_q < CW'(N - 1)) ? rd_data : 1'b0;
               if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(N + TAIL - 1)) state_q <= S_WAIT;
            end
            S_WAIT: begin
               seq_q <= 1'b0;
               if (i_blob_done) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_valid = valid_q;
   assign o_seq   = seq_q;
   assign o_busy  = busy_q;
   assign o_ones  = ones_q;

endmodule

// File: tb/tb_blob_frame_binarizer.sv
// Directed bench for blob_frame_binarizer on an 8x4 frame: capture, threshold,
// restart on SOF, stream timing, ignored control inputs and asynchronous abort.

module tb_blob_frame_binarizer;

   localparam int PIX_W = 10;
   localparam int NPIX  = 32;
   localparam int TAIL  = 2;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic             i_trigger;
   logic             i_pix_valid;
   logic             i_sof;
   logic [PIX_W-1:0] i_r, i_g, i_b;
   logic [PIX_W-1:0] i_thresh;
   logic             i_invert;
   logic             i_blob_done;
   logic             o_valid;
   logic             o_seq;
   logic             o_busy;
   logic [18:0]      o_ones;

   int n_cmp = 0;
   int n_err = 0;
   logic [PIX_W-1:0] frame_pix [NPIX];

   blob_frame_binarizer #(
      .IMG_COL (8),
      .IMG_ROW (4),
      .PIX_W   (PIX_W),
      .TAIL    (TAIL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_trigger   (i_trigger),
      .i_pix_valid (i_pix_valid),
      .i_sof       (i_sof),
      .i_r         (i_r),
      .i_g         (i_g),
      .i_b         (i_b),
      .i_thresh    (i_thresh),
      .i_invert    (i_invert),
      .i_blob_done (i_blob_done),
      .o_valid     (o_valid),
      .o_seq       (o_seq),
      .o_busy      (o_busy),
      .o_ones      (o_ones)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_pix(input logic [PIX_W-1:0] v);
      i_r = v;
      i_g = v;
      i_b = v;
   endtask

   task automatic trigger(input logic [PIX_W-1:0] thr, input logic inv);
      i_thresh  = thr;
      i_invert  = inv;
      i_trigger = 1'b1;
      tick();
      i_trigger = 1'b0;
      check("trigger_busy", o_busy, 1);
   endtask

   task automatic send_frame(input bit gaps, input bit chg_thresh);
      for (int k = 0; k < NPIX; k++) begin
         if (gaps && k > 0) begin
            i_pix_valid = 1'b0;
            set_pix(10'd1023);
            tick();
         end
         i_pix_valid = 1'b1;
         i_sof       = (k == 0);
         set_pix(frame_pix[k]);
         if (chg_thresh && k == 5) i_thresh = 10'd0;
         tick();
      end
      i_pix_valid = 1'b0;
      i_sof       = 1'b0;
   endtask

   task automatic run_stream(input string name, input logic [31:0] exp_bits,
                             input logic [31:0] exp_ones, input bit poke);
      logic [31:0] got;
      int n;
      int vcnt;
      int tail_or;
      n = 0;
      while (!o_valid && n < 200) begin
         tick();
         n++;
      end
      check({name, "_valid"}, o_valid, 1);
      check({name, "_ones"}, o_ones, exp_ones);
      got  = '0;
      vcnt = 0;
      for (int k = 0; k < NPIX; k++) begin
         if (poke && k == 10) begin
            i_trigger   = 1'b1;
            i_blob_done = 1'b1;
         end
         tick();
         i_trigger   = 1'b0;
         i_blob_done = 1'b0;
         got[k] = o_seq;
         vcnt += int'(o_valid);
      end
      check({name, "_stream"}, got, exp_bits);
      check({name, "_valid_pulses"}, vcnt, 0);
      tail_or = 0;
      for (int t = 0; t < TAIL; t++) begin
         tick();
         tail_or += int'(o_seq);
      end
      check({name, "_tail"}, tail_or, 0);
      tick();
      check({name, "_wait_busy"}, o_busy, 1);
      check({name, "_wait_seq"}, o_seq, 0);
      if (poke) begin
         i_trigger = 1'b1;
         tick();
         i_trigger = 1'b0;
         tick();
         check({name, "_wait_trig_busy"}, o_busy, 1);
      end
      i_blob_done = 1'b1;
      tick();
      i_blob_done = 1'b0;
      check({name, "_done_busy"}, o_busy, 0);
      if (poke) begin
         repeat (5) tick();
         check({name, "_idle_stays"}, o_busy, 0);
      end
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_trigger   = 1'b0;
      i_pix_valid = 1'b0;
      i_sof       = 1'b0;
      set_pix('0);
      i_thresh    = '0;
      i_invert    = 1'b0;
      i_blob_done = 1'b0;
      #23;
      check("rst_valid", o_valid, 0);
      check("rst_seq", o_seq, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ones", o_ones, 0);
      i_rst_n = 1'b1;
      tick();

      // Uniform gray 600 above threshold 512
      for (int k = 0; k < NPIX; k++) frame_pix[k] = 10'd600;
      trigger(10'd512, 1'b0);
      send_frame(1'b0, 1'b0);
      run_stream("t1", 32'hFFFF_FFFF, 32, 1'b0);

      // Checkerboard with pixel-valid gaps
      for (int k = 0; k < NPIX; k++)
         frame_pix[k] = (((k / 8) + (k % 8)) % 2 == 1) ? 10'd1023 : 10'd0;
      trigger(10'd512, 1'b0);
      send_frame(1'b1, 1'b0);
      run_stream("t2", 32'h55AA_55AA, 16, 1'b0);

      // Inverted, threshold changed mid-capture
      trigger(10'd512, 1'b1);
      send_frame(1'b0, 1'b1);
      run_stream("t3", 32'hAA55_AA55, 16, 1'b0);
      i_thresh = 10'd512;

      // Junk before SOF, then a restart at pixel 10
      trigger(10'd512, 1'b0);
      for (int k = 0; k < 3; k++) begin
         i_pix_valid = 1'b1;
         i_sof       = 1'b0;
         set_pix(10'd1023);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         i_pix_valid = 1'b1;
         i_sof       = (k == 0);
         set_pix(10'd1023);
         tick();
      end
      check("t4_still_busy", o_busy, 1);
      for (int k = 0; k < NPIX; k++) frame_pix[k] = (k % 3 == 0) ? 10'd900 : 10'd100;
      send_frame(1'b0, 1'b0);
      run_stream("t4", 32'h4924_9249, 11, 1'b0);

      // Trigger/done pokes outside their accepting states
      for (int k = 0; k < NPIX; k++) frame_pix[k] = 10'd600;
      trigger(10'd512, 1'b0);
      send_frame(1'b0, 1'b0);
      run_stream("t5", 32'hFFFF_FFFF, 32, 1'b1);

      // Asynchronous reset in the middle of streaming
      trigger(10'd512, 1'b0);
      send_frame(1'b0, 1'b0);
      repeat (5) tick();
      check("t6_pre_busy", o_busy, 1);
      #2 i_rst_n = 1'b0;
      #1;
      check("t6_rst_seq", o_seq, 0);
      check("t6_rst_valid", o_valid, 0);
      check("t6_rst_busy", o_busy, 0);
      check("t6_rst_ones", o_ones, 0);
      #3 i_rst_n = 1'b1;
      tick();
      send_frame(1'b0, 1'b0);
      repeat (3) tick();
      check("t6_idle_busy", o_busy, 0);
      check("t6_idle_valid", o_valid, 0);
      check("t6_idle_ones", o_ones, 0);
      trigger(10'd512, 1'b0);
      send_frame(1'b0, 1'b0);
      run_stream("t6", 32'hFFFF_FFFF, 32, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
